// File: rtl/tensor_accel_pkg.sv
// Shared definitions for the tensor accelerator tile.
// INSTR_W / PC_W : LCP command width and program-counter width.
// OP_NOP / OP_HALT : opcode byte values (bits [127:120] of a command).
// rd_tag_t : per-stage tag carried down the instruction-fetch read pipeline.
package tensor_accel_pkg;

    localparam int unsigned INSTR_W = 128;
    localparam int unsigned PC_W    = 20;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_HALT = 8'hFF;

    typedef struct packed {
        logic valid;
        logic oor;
    } rd_tag_t;

endpackage

// File: rtl/imem_sram_sp.sv
// Single-port synchronous instruction RAM, DEPTH x DATA_W, one-cycle read.
// Ports:
//   clk   : clock
//   en    : port enable (read when we=0, write when we=1)
//   we    : write enable
//   addr  : word index
//   wdata : write data
//   rdata : read data, updated one cycle after an enabled read, held otherwise
// Contents and rdata are not reset.
module imem_sram_sp #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/lcp_imem_responder.sv
// Instruction-memory responder for the LCP fetch port. Serves fetches after
// READ_LAT cycles and accepts program-load words when the LCP is not fetching.
// Fetch has strict priority over load on the shared single-port array.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   imem_addr, imem_re           : fetch request (no backpressure)
//   imem_data, imem_valid        : fetch response, one pulse per request
//   imem_error                   : response was for an address >= DEPTH
//   ld_valid/ld_ready            : load handshake; ld_addr/ld_data/ld_last payload
//   ld_done                      : pulse the cycle after the ld_last beat is accepted
//   ld_error                     : sticky, an accepted load address was >= DEPTH
//   fetch_cnt, load_cnt          : accepted fetch / load beat counters (wrapping)
module lcp_imem_responder
    import tensor_accel_pkg::*;
#(
    parameter int unsigned DATA_W   = INSTR_W,
    parameter int unsigned ADDR_W   = PC_W,
    parameter int unsigned DEPTH    = 4096,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_re,
    output logic [DATA_W-1:0] imem_data,
    output logic              imem_valid,
    output logic              imem_error,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_done,
    output logic              ld_error,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       load_cnt
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic              f_oor;
    logic              l_oor;
    logic              ld_acc;
    logic              ram_en;
    logic              ram_we;
    logic [IDX_W-1:0]  ram_addr;
    logic [DATA_W-1:0] ram_q;

    rd_tag_t           s1_q;
    logic [DATA_W-1:0] s1_data;
    rd_tag_t           out_tag;
    logic [DATA_W-1:0] out_data;
    logic [DATA_W-1:0] hold_q;

    assign f_oor = imem_addr >= ADDR_W'(DEPTH);
    assign l_oor = ld_addr >= ADDR_W'(DEPTH);

    assign ld_ready = !imem_re && !rst;
    assign ld_acc   = ld_valid && ld_ready;

    // Out-of-range fetches and loads never touch the array.
    assign ram_we   = ld_acc && !l_oor;
    assign ram_en   = (imem_re && !f_oor) || ram_we;
    assign ram_addr = imem_re ? imem_addr[IDX_W-1:0] : ld_addr[IDX_W-1:0];

    imem_sram_sp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_sram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ld_data),
        .rdata (ram_q)
    );

    // Stage 1: tag aligned with the RAM output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
        end else begin
            s1_q.valid <= imem_re;
            s1_q.oor   <= f_oor;
        end
    end

    // ram_q is stale for out-of-range requests, so force zero here.
    assign s1_data = s1_q.oor ? '0 : ram_q;

    generate
        if (READ_LAT <= 1) begin : g_lat1
            assign out_tag  = s1_q;
            assign out_data = s1_data;
        end else begin : g_pipe
            rd_tag_t           tag_q  [READ_LAT-1];
            logic [DATA_W-1:0] data_q [READ_LAT-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int unsigned i = 0; i < READ_LAT - 1; i++) begin
                        tag_q[i]  <= '0;
                        data_q[i] <= '0;
                    end
                end else begin
                    tag_q[0]  <= s1_q;
                    data_q[0] <= s1_data;
                    for (int unsigned i = 1; i < READ_LAT - 1; i++) begin
                        tag_q[i]  <= tag_q[i-1];
                        data_q[i] <= data_q[i-1];
                    end
                end
            end

            assign out_tag  = tag_q[READ_LAT-2];
            assign out_data = data_q[READ_LAT-2];
        end
    endgenerate

    // imem_data shows the response on a valid pulse and holds it afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else if (out_tag.valid) begin
            hold_q <= out_data;
        end
    end

    assign imem_valid = out_tag.valid;
    assign imem_error = out_tag.valid && out_tag.oor;
    assign imem_data  = out_tag.valid ? out_data : hold_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_done   <= 1'b0;
            ld_error  <= 1'b0;
            fetch_cnt <= '0;
            load_cnt  <= '0;
        end else begin
            ld_done <= ld_acc && ld_last;
            if (ld_acc && l_oor) begin
                ld_error <= 1'b1;
            end
            if (imem_re) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (ld_acc) begin
                load_cnt <= load_cnt + 32'd1;
            end
        end
    end

endmodule
